parallel_serial_mc: RTL and testbench

Multi-lane, parametrised successor to the single-lane frame deserialiser. Samples NCH serial lanes every clock, assembles FRAME_WIDTH-bit frames per lane, and packs them into FIFO_WIDTH-bit words with a small header. Output goes to a downstream FIFO's write port. Supports single-shot, continuous and externally triggered capture, with double-buffered frames, backpressure and overflow accounting. Sits in the clk_sub domain between pixel readout lines and the readout FIFO.

---
 rtl/parallel_serial_mc.sv | 209 ++++++++++++++++++++
 tb/tb_parallel_serial_mc.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_serial_mc.sv
// Multi-lane serial frame capture: samples NCH lanes MSB-first, double-buffers whole frames
// and emits them as FIFO_WIDTH-bit words {sof, ovf, chunk[1:0], payload} to a FIFO write port.
module parallel_serial_mc #(
   parameter int NDATA       = 1,
   parameter int NCH         = 8,
   parameter int FRAME_WIDTH = 48,
   parameter int FIFO_WIDTH  = 36
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  trigger,
   input  logic [1:0]            mode,
   input  logic [NCH-1:0]        fd,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic [15:0]           frames_done,
   output logic [15:0]           drop_count
);

   localparam int PW     = FIFO_WIDTH - 4;
   localparam int NCHUNK = (FRAME_WIDTH + PW - 1) / PW;
   localparam int PADW   = NCHUNK * PW;
   localparam int PADZ   = PADW - FRAME_WIDTH;
   localparam int BW     = $clog2(FRAME_WIDTH);
   localparam int LW     = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int FCW    = NDATA + 1;

   localparam logic [FCW-1:0] LAST_FRAME = FCW'((1 << NDATA) - 1);
   localparam logic [BW-1:0]  LAST_BIT   = BW'(FRAME_WIDTH - 1);
   localparam logic [LW-1:0]  LAST_LANE  = LW'(NCH - 1);
   localparam logic [CW-1:0]  LAST_CHUNK = CW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARM     = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]     state_reg, state_next;
   logic [1:0]     mode_reg, mode_next;
   logic [BW-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
   logic           shadow_valid_reg, shadow_valid_next;
   logic [LW-1:0]  lane_idx_reg, lane_idx_next;
   logic [CW-1:0]  chunk_idx_reg, chunk_idx_next;
   logic           ovf_reg, ovf_next;
   logic [15:0]    frames_done_reg, frames_done_next;
   logic [15:0]    drop_count_reg, drop_count_next;

   logic                      start_ok, stop_now, wrap, last_word, wr, shadow_free, load, drop;
   logic [NCH-1:0][PADW-1:0]  lane_pad;
   logic [PADW-1:0]           sel_pad;
   logic [PW-1:0]             payload;
   logic [1:0]                chunk_hdr;
   logic                      sof;

   assign start_ok    = start && (state_reg == S_IDLE);
   assign stop_now    = stop && (state_reg == S_CAPTURE) && (mode_reg == 2'd1);
   assign wrap        = (state_reg == S_CAPTURE) && (bit_cnt_reg == LAST_BIT) && !stop_now;
   assign last_word   = (lane_idx_reg == LAST_LANE) && (chunk_idx_reg == LAST_CHUNK);
   assign wr          = shadow_valid_reg && !fifo_full;
   // A shadow whose final word leaves on this edge can accept the next frame on the same edge.
   assign shadow_free = !shadow_valid_reg || (wr && last_word);
   assign load        = wrap && shadow_free;
   assign drop        = wrap && !shadow_free;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_lane
         logic [FRAME_WIDTH-1:0] shift_reg;
         logic [FRAME_WIDTH-1:0] shadow_reg;
         logic [FRAME_WIDTH-1:0] shift_next;

         assign shift_next = {shift_reg[FRAME_WIDTH-2:0], fd[gi]};

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               shift_reg  <= '0;
               shadow_reg <= '0;
            end else begin
               if (state_reg == S_CAPTURE)
                  shift_reg <= shift_next;
               if (load)
                  shadow_reg <= shift_next;
            end
         end

         // Left-align the frame so the final chunk is zero-padded in its low bits.
         assign lane_pad[gi] = PADW'(shadow_reg) << PADZ;
      end
   endgenerate

   always_comb begin
      sel_pad   = lane_pad[lane_idx_reg];
      payload   = PW'(sel_pad >> (PW * (NCHUNK - 1 - int'(chunk_idx_reg))));
      chunk_hdr = 2'(chunk_idx_reg);
      sof       = (lane_idx_reg == '0) && (chunk_idx_reg == '0);
   end

   assign fifo_wr_en  = wr;
   assign data_out    = shadow_valid_reg ? {sof, ovf_reg, chunk_hdr, payload} : '0;
   assign busy        = (state_reg != S_IDLE);
   assign frames_done = frames_done_reg;
   assign drop_count  = drop_count_reg;

   always_comb begin
      state_next        = state_reg;
      mode_next         = mode_reg;
      bit_cnt_next      = '0;
      frame_cnt_next    = frame_cnt_reg;
      shadow_valid_next = shadow_valid_reg;
      lane_idx_next     = lane_idx_reg;
      chunk_idx_next    = chunk_idx_reg;
      ovf_next          = ovf_reg;
      frames_done_next  = frames_done_reg;
      drop_count_next   = drop_count_reg;

      case (state_reg)
         S_IDLE: begin
            if (start)
               state_next = (mode == 2'd2) ? S_ARM : S_CAPTURE;
         end
         S_ARM: begin
            if (stop)
               state_next = S_IDLE;
            else if (trigger)
               state_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (stop_now)
               state_next = S_DRAIN;
            else if (wrap && (frame_cnt_reg == LAST_FRAME) && (mode_reg != 2'd1))
               state_next = S_DRAIN;
            if (!stop_now && !wrap)
               bit_cnt_next = bit_cnt_reg + BW'(1);
         end
         default: begin
            if (shadow_free)
               state_next = S_IDLE;
         end
      endcase

      if (start_ok) begin
         mode_next        = (mode == 2'd3) ? 2'd0 : mode;
         frame_cnt_next   = '0;
         ovf_next         = 1'b0;
         frames_done_next = '0;
         drop_count_next  = '0;
      end

      if (wrap)
         frame_cnt_next = frame_cnt_reg + FCW'(1);

      if (wr) begin
         ovf_next = 1'b0;
         if (chunk_idx_reg == LAST_CHUNK) begin
            chunk_idx_next = '0;
            lane_idx_next  = last_word ? '0 : lane_idx_reg + LW'(1);
         end else begin
            chunk_idx_next = chunk_idx_reg + CW'(1);
         end
         if (last_word) begin
            shadow_valid_next = 1'b0;
            if (frames_done_reg != 16'hFFFF)
               frames_done_next = frames_done_reg + 16'd1;
         end
      end

      if (load)
         shadow_valid_next = 1'b1;

      if (drop) begin
         ovf_next = 1'b1;
         if (drop_count_reg != 16'hFFFF)
            drop_count_next = drop_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= S_IDLE;
         mode_reg         <= 2'd0;
         bit_cnt_reg      <= '0;
         frame_cnt_reg    <= '0;
         shadow_valid_reg <= 1'b0;
         lane_idx_reg     <= '0;
         chunk_idx_reg    <= '0;
         ovf_reg          <= 1'b0;
         frames_done_reg  <= '0;
         drop_count_reg   <= '0;
      end else begin
         state_reg        <= state_next;
         mode_reg         <= mode_next;
         bit_cnt_reg      <= bit_cnt_next;
         frame_cnt_reg    <= frame_cnt_next;
         shadow_valid_reg <= shadow_valid_next;
         lane_idx_reg     <= lane_idx_next;
         chunk_idx_reg    <= chunk_idx_next;
         ovf_reg          <= ovf_next;
         frames_done_reg  <= frames_done_next;
         drop_count_reg   <= drop_count_next;
      end
   end

endmodule

// File: tb/tb_parallel_serial_mc.sv
// Scoreboard bench for parallel_serial_mc: expected words are queued when a capture is launched
// and popped as the DUT writes them; control and counter outputs are checked between runs.
module tb_parallel_serial_mc;

   localparam int NCH = 2;
   localparam int FW  = 48;
   localparam int FWD = 36;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic           stop = 1'b0;
   logic           trigger = 1'b0;
   logic [1:0]     mode = 2'd0;
   logic [NCH-1:0] fd = '0;
   logic           fifo_full = 1'b0;
   logic           fifo_wr_en;
   logic [FWD-1:0] data_out;
   logic           busy;
   logic [15:0]    frames_done;
   logic [15:0]    drop_count;

   parallel_serial_mc #(
      .NDATA(1), .NCH(NCH), .FRAME_WIDTH(FW), .FIFO_WIDTH(FWD)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .trigger(trigger), .mode(mode),
      .fd(fd), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .data_out(data_out),
      .busy(busy), .frames_done(frames_done), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int             n_total = 0;
   int             n_bad = 0;
   int             cyc = 0;
   int             first_wr_cyc = -1;
   int             ref_cyc = 0;
   int             n_words = 0;
   int             pos = 0;
   bit             feed = 1'b0;
   logic [FWD-1:0] exp_q[$];
   logic [FWD-1:0] mon_exp;
   logic [FW-1:0]  pat0, pat1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (rst) begin
         if (fifo_full)
            check_val("wr_while_full", 64'(fifo_wr_en), 64'd0);
         if (fifo_wr_en) begin
            if (first_wr_cyc < 0)
               first_wr_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
               check_val("unexpected_wr_queue", 64'(exp_q.size()), 64'd1);
            end else begin
               mon_exp = exp_q.pop_front();
               check_val($sformatf("word%0d", n_words), 64'(data_out), 64'(mon_exp));
               $display("word %0d: data_out=%09h expected=%09h", n_words, data_out, mon_exp);
            end
            n_words++;
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         start   = 1'b0;
         stop    = 1'b0;
         trigger = 1'b0;
         if (feed) begin
            fd  = {pat1[FW-1-pos], pat0[FW-1-pos]};
            pos = (pos + 1) % FW;
         end else begin
            fd = NCH'($urandom);
         end
      end
   endtask

   task automatic push_frame(input bit ovf_first);
      for (int l = 0; l < NCH; l++) begin
         for (int k = 0; k < 2; k++) begin
            logic [FW-1:0] p;
            logic [31:0]   pl;
            logic          sof;
            logic          ov;
            p   = (l == 0) ? pat0 : pat1;
            pl  = (k == 0) ? p[47:16] : {p[15:0], 16'h0000};
            sof = (l == 0) && (k == 0);
            ov  = ovf_first && sof;
            exp_q.push_back({sof, ov, 1'b0, (k == 1), pl});
         end
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (!busy)
            return;
         step(1);
      end
      check_val("idle_timeout_busy", 64'(busy), 64'd0);
   endtask

   task automatic new_pattern();
      pat0 = FW'({$urandom, $urandom});
      pat1 = FW'({$urandom, $urandom});
   endtask

   task automatic launch(input logic [1:0] m, input bit with_stop);
      first_wr_cyc = -1;
      mode  = m;
      start = 1'b1;
      stop  = with_stop;
      feed  = (m != 2'd2);
      pos   = 0;
      step(1);
      ref_cyc = cyc;
   endtask

   initial begin
      #(10 * 20000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset values while rst is held low
      #2;
      check_val("rst_wr_en", 64'(fifo_wr_en), 64'd0);
      check_val("rst_data_out", 64'(data_out), 64'd0);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_frames_done", 64'(frames_done), 64'd0);
      check_val("rst_drop_count", 64'(drop_count), 64'd0);
      step(2);
      rst = 1'b1;
      step(2);

      // Mode 0 with the reference pattern
      pat0 = 48'hA5A5_1234_5678;
      pat1 = ~pat0;
      push_frame(1'b0);
      push_frame(1'b0);
      launch(2'd0, 1'b0);
      check_val("m0_busy", 64'(busy), 64'd1);
      check_val("m0_frames_start", 64'(frames_done), 64'd0);
      wait_idle(400);
      check_val("m0_latency", 64'(first_wr_cyc - ref_cyc), 64'd49);
      check_val("m0_frames_done", 64'(frames_done), 64'd2);
      check_val("m0_drop_count", 64'(drop_count), 64'd0);
      check_val("m0_queue_left", 64'(exp_q.size()), 64'd0);

      // Trigger outside ARM is ignored; stop in ARM returns to IDLE
      feed = 1'b0;
      trigger = 1'b1;
      step(1);
      check_val("trig_idle_busy", 64'(busy), 64'd0);
      launch(2'd2, 1'b0);
      check_val("arm_busy", 64'(busy), 64'd1);
      stop = 1'b1;
      step(1);
      check_val("arm_stop_busy", 64'(busy), 64'd0);

      // Mode 2: twenty cycles armed, then trigger
      new_pattern();
      launch(2'd2, 1'b0);
      step(19);
      check_val("m2_armed_busy", 64'(busy), 64'd1);
      check_val("m2_no_wr_before_trig", 64'(first_wr_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      push_frame(1'b0);
      push_frame(1'b0);
      trigger = 1'b1;
      feed = 1'b1;
      pos = 0;
      step(1);
      ref_cyc = cyc;
      wait_idle(400);
      check_val("m2_latency", 64'(first_wr_cyc - ref_cyc), 64'd49);
      check_val("m2_frames_done", 64'(frames_done), 64'd2);
      check_val("m2_queue_left", 64'(exp_q.size()), 64'd0);

      // Mode 1, start and stop together (start wins), then stop at cycle 130
      new_pattern();
      push_frame(1'b0);
      push_frame(1'b0);
      launch(2'd1, 1'b1);
      check_val("m1_start_beats_stop", 64'(busy), 64'd1);
      step(129);
      stop = 1'b1;
      step(1);
      wait_idle(100);
      check_val("m1_frames_done", 64'(frames_done), 64'd2);
      check_val("m1_drop_count", 64'(drop_count), 64'd0);
      check_val("m1_queue_left", 64'(exp_q.size()), 64'd0);

      // Mode 1 with fifo_full held for 200 cycles: drops, ovf on first word after release
      new_pattern();
      push_frame(1'b1);
      push_frame(1'b0);
      fifo_full = 1'b1;
      launch(2'd1, 1'b0);
      step(199);
      fifo_full = 1'b0;
      check_val("full_drop_ge3", 64'(drop_count >= 16'd3), 64'd1);
      step(50);
      stop = 1'b1;
      step(1);
      wait_idle(100);
      check_val("full_frames_done", 64'(frames_done), 64'd2);
      check_val("full_queue_left", 64'(exp_q.size()), 64'd0);

      // Three-cycle stall on the second word of the first frame
      new_pattern();
      push_frame(1'b0);
      push_frame(1'b0);
      launch(2'd0, 1'b0);
      for (int i = 0; i < 100 && !fifo_wr_en; i++)
         step(1);
      check_val("stall_first_wr_seen", 64'(fifo_wr_en), 64'd1);
      step(1);
      fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (exp_q.size() == 0)
            check_val("stall_queue_empty", 64'(exp_q.size()), 64'd1);
         else
            check_val($sformatf("stall_hold%0d", i), 64'(data_out), 64'(exp_q[0]));
      end
      fifo_full = 1'b0;
      wait_idle(400);
      check_val("stall_frames_done", 64'(frames_done), 64'd2);
      check_val("stall_queue_left", 64'(exp_q.size()), 64'd0);

      // Reset in DRAIN: two words of the second frame still owed
      new_pattern();
      push_frame(1'b0);
      push_frame(1'b0);
      launch(2'd0, 1'b0);
      step(98);
      check_val("drain_busy", 64'(busy), 64'd1);
      check_val("drain_frames_done", 64'(frames_done), 64'd1);
      rst = 1'b0;
      #1;
      check_val("abort_wr_en", 64'(fifo_wr_en), 64'd0);
      check_val("abort_data_out", 64'(data_out), 64'd0);
      check_val("abort_busy", 64'(busy), 64'd0);
      check_val("abort_frames_done", 64'(frames_done), 64'd0);
      check_val("abort_drop_count", 64'(drop_count), 64'd0);
      check_val("abort_words_owed", 64'(exp_q.size()), 64'd2);
      exp_q.delete();
      step(2);
      rst = 1'b1;
      step(2);

      // Clean run after reset, mode 3 behaving as mode 0
      new_pattern();
      push_frame(1'b0);
      push_frame(1'b0);
      launch(2'd3, 1'b0);
      check_val("post_rst_frames_start", 64'(frames_done), 64'd0);
      wait_idle(400);
      check_val("post_rst_latency", 64'(first_wr_cyc - ref_cyc), 64'd49);
      check_val("post_rst_frames_done", 64'(frames_done), 64'd2);
      check_val("post_rst_drop_count", 64'(drop_count), 64'd0);
      check_val("post_rst_queue_left", 64'(exp_q.size()), 64'd0);

      step(5);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
